// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// Serial receive front end. Oversamples the asynchronous UART RX pin at the
// system clock, frames 8N1 characters (start bit, 8 data bits LSB first,
// one stop bit) and presents each correctly framed byte with a one-cycle
// valid pulse. A single holding register (rdata) is the only buffering.
//
// Frame timing is counted from the first IDLE cycle that sees the
// synchronized line low (frame cycle 0). With H = CLK_PER_HALF_BIT:
//   start bit sampled at frame cycle H
//   data bit n sampled at frame cycle H + 2*H*(n+1), n = 0..7
//   stop bit sampled at frame cycle 19*H
//   rdata_valid high during frame cycle 19*H+1
//
// Parameters:
//   CLK_PER_HALF_BIT : clock cycles per half bit period (must be >= 4)
//
// Ports:
//   clk         : system clock, all state on rising edge
//   rstn        : asynchronous active-low reset
//   uart_rx     : raw serial line, idle high, asynchronous to clk
//   rdata       : last correctly framed byte
//   rdata_valid : one-cycle pulse, rdata updated this cycle
//   ferr        : framing error flag, sticky until the next good frame
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int CLK_PER_HALF_BIT = 520
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_rx,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       ferr
);

    // Counter must reach 2*H-1 (one full bit period minus one).
    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    logic             sync1_r;
    logic             rxs_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;

    // Two-flop synchronizer for the asynchronous RX line; resets to idle-high
    // so a reset never manufactures a falling edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= uart_rx;
            rxs_r   <= sync1_r;
        end
    end

    // Frame state machine with registered outputs. The counter restarts on
    // every state entry and after every data-bit sample, so each sample point
    // lands at the centre of its bit cell.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            ferr        <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (!rxs_r) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (!rxs_r) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            // Line back high at mid-start: treat as a glitch.
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        shift_r <= {rxs_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (rxs_r) begin
                            rdata       <= shift_r;
                            rdata_valid <= 1'b1;
                            ferr        <= 1'b0;
                            // Returning at mid-stop lets a back-to-back start
                            // bit be caught on its first low cycle.
                            state_r     <= IDLE;
                        end else begin
                            ferr    <= 1'b1;
                            state_r <= BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                BREAK: begin
                    // Hold off until the line recovers so a held-low line is
                    // not re-framed as an endless stream of start bits.
                    cnt_r <= CNT_ZERO;
                    if (rxs_r) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BREAK;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Directed self-checking bench for uart_rx_frame with H = 4 (bit period of
// 8 cycles). Serial frames are driven on falling clock edges; a monitor
// records every rdata_valid pulse (cycle stamp and byte) on falling edges.
//
// Pulse latency: the start edge is driven at cycle stamp c0; two synchronizer
// flops put it in front of IDLE one posedge later (frame cycle 0 ends at
// posedge c0+3), and the valid pulse is registered at the end of frame cycle
// 19*H = 76, i.e. posedge c0+79. Hence the expected stamp delta of 79.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       uart_rx;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       ferr;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         c0          = 0;
    int         bit_len [10];

    int         pulse_cyc [$];
    logic [7:0] pulse_dat [$];
    logic       prev_valid  = 1'b0;
    logic       consec_seen = 1'b0;

    uart_rx_frame #(
        .CLK_PER_HALF_BIT(H)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .uart_rx    (uart_rx),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .ferr       (ferr)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Posedge counter used for cycle stamps
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse and flag back-to-back valid cycles
    always @(negedge clk) begin
        if (rdata_valid) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(rdata);
            if (prev_valid) consec_seen <= 1'b1;
        end
        prev_valid <= rdata_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pcyc(input int i);
        if (i < pulse_cyc.size()) return pulse_cyc[i] - c0;
        else return -1;
    endfunction

    function automatic logic [7:0] pdat(input int i);
        if (i < pulse_dat.size()) return pulse_dat[i];
        else return 8'hxx;
    endfunction

    task automatic hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(1'b1, n);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_v);
        logic [9:0] fr;
        fr = {stop_v, d, 1'b0};
        for (int i = 0; i < 10; i++) hold(fr[i], bit_len[i]);
    endtask

    task automatic new_test();
        pulse_cyc.delete();
        pulse_dat.delete();
        c0 = cyc;
    endtask

    task automatic nominal_len();
        for (int i = 0; i < 10; i++) bit_len[i] = 2 * H;
    endtask

    initial begin
        nominal_len();
        rstn    = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rdata", {24'h0, rdata}, 32'h00);
        chk("reset_valid", {31'h0, rdata_valid}, 32'h0);
        chk("reset_ferr",  {31'h0, ferr}, 32'h0);
        rstn = 1'b1;
        idle(10);

        // Clean single frame
        new_test();
        send(8'h55, 1'b1);
        idle(20);
        chk("x55_count", pulse_cyc.size(), 32'd1);
        chk("x55_time",  pcyc(0), 32'd79);
        chk("x55_data",  {24'h0, pdat(0)}, 32'h55);
        chk("x55_rdata", {24'h0, rdata}, 32'h55);
        chk("x55_ferr",  {31'h0, ferr}, 32'h0);

        // Back-to-back frames with no idle gap
        new_test();
        send(8'hA3, 1'b1);
        send(8'h0F, 1'b1);
        idle(20);
        chk("b2b_count",   pulse_cyc.size(), 32'd2);
        chk("b2b_time0",   pcyc(0), 32'd79);
        chk("b2b_spacing", pcyc(1) - pcyc(0), 32'd80);
        chk("b2b_data0",   {24'h0, pdat(0)}, 32'hA3);
        chk("b2b_data1",   {24'h0, pdat(1)}, 32'h0F);

        // Short low glitch aborts at mid-start
        new_test();
        hold(1'b0, 2);
        idle(20);
        chk("glitch_count", pulse_cyc.size(), 32'd0);
        chk("glitch_rdata", {24'h0, rdata}, 32'h0F);
        chk("glitch_ferr",  {31'h0, ferr}, 32'h0);
        new_test();
        send(8'h3C, 1'b1);
        idle(20);
        chk("x3c_count", pulse_cyc.size(), 32'd1);
        chk("x3c_time",  pcyc(0), 32'd79);
        chk("x3c_data",  {24'h0, pdat(0)}, 32'h3C);

        // Bad stop bit followed by a held-low line
        new_test();
        send(8'h81, 1'b0);
        hold(1'b0, 40);
        chk("brk_ferr_low", {31'h0, ferr}, 32'h1);
        idle(20);
        chk("brk_count", pulse_cyc.size(), 32'd0);
        chk("brk_rdata", {24'h0, rdata}, 32'h3C);
        chk("brk_ferr",  {31'h0, ferr}, 32'h1);
        new_test();
        send(8'h7E, 1'b1);
        idle(20);
        chk("x7e_count", pulse_cyc.size(), 32'd1);
        chk("x7e_data",  {24'h0, pdat(0)}, 32'h7E);
        chk("x7e_rdata", {24'h0, rdata}, 32'h7E);
        chk("x7e_ferr",  {31'h0, ferr}, 32'h0);

        // Reset in the middle of data bit 4 of a 0xFF frame
        new_test();
        hold(1'b0, 8);
        hold(1'b1, 32);
        hold(1'b1, 4);
        rstn = 1'b0;
        #1;
        chk("rst_async_rdata", {24'h0, rdata}, 32'h00);
        chk("rst_async_valid", {31'h0, rdata_valid}, 32'h0);
        chk("rst_async_ferr",  {31'h0, ferr}, 32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        hold(1'b1, 4);
        hold(1'b1, 24);
        hold(1'b1, 8);
        idle(20);
        chk("rst_rest_count", pulse_cyc.size(), 32'd0);
        chk("rst_rest_rdata", {24'h0, rdata}, 32'h00);
        new_test();
        send(8'h12, 1'b1);
        idle(20);
        chk("x12_count", pulse_cyc.size(), 32'd1);
        chk("x12_time",  pcyc(0), 32'd79);
        chk("x12_data",  {24'h0, pdat(0)}, 32'h12);

        // Late edges: every edge after the start edge shifted one cycle later
        new_test();
        bit_len[0] = 2 * H + 1;
        bit_len[9] = 2 * H - 1;
        send(8'h96, 1'b1);
        idle(20);
        chk("late_count", pulse_cyc.size(), 32'd1);
        chk("late_data",  {24'h0, pdat(0)}, 32'h96);
        chk("late_ferr",  {31'h0, ferr}, 32'h0);

        // Early edges: every edge after the start edge shifted one cycle earlier
        new_test();
        bit_len[0] = 2 * H - 1;
        bit_len[9] = 2 * H + 1;
        send(8'h96, 1'b1);
        idle(20);
        chk("early_count", pulse_cyc.size(), 32'd1);
        chk("early_data",  {24'h0, pdat(0)}, 32'h96);
        chk("early_ferr",  {31'h0, ferr}, 32'h0);
        nominal_len();

        chk("no_consec_valid", {31'h0, consec_seen}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
